// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction fetch stage
// and its instruction memory.
package imem_pkg;

  localparam int DEF_DEPTH = 128;
  localparam int IDX_W = $clog2(DEF_DEPTH);

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] word_index(
    input logic [31:0] addr
  );
    return addr >> 2;
  endfunction

endpackage

// File: rtl/imem_sp_ram.sv
// Word-addressed instruction RAM: synchronous write, registered
// read with read-old-data on same-index collisions.
module imem_sp_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents survive reset so the array can be preloaded under it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-cycle fetch stage: fetch PC, redirect, stall and
// alignment/range fault handling in front of the instruction RAM.
module instr_fetch_unit
  import imem_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 32,
  parameter int              IMEM_DEPTH = 128,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          branch,
  input  logic                          jump,
  input  logic [ADDR_W-1:0]             branch_addr,
  input  logic [ADDR_W-1:0]             jump_addr,
  input  logic                          id_ready,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [DATA_W-1:0]             imem_wdata,
  output logic [ADDR_W-1:0]             pc_out,
  output logic [DATA_W-1:0]             ir_out,
  output logic                          if_valid,
  output logic                          fault,
  output logic [ADDR_W-1:0]             fault_addr
);

  localparam int IW = $clog2(IMEM_DEPTH);

  fetch_state_t      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] tgt;
  logic              redir;
  logic              advance;
  logic              pc_ok;
  logic              tgt_ok;
  logic              rd_en;

  function automatic logic addr_ok(
    input logic [ADDR_W-1:0] a
  );
    return (a[1:0] == 2'b00) &&
      ({2'b00, a[ADDR_W-1:2]} < ADDR_W'(IMEM_DEPTH));
  endfunction

  always_comb begin
    redir   = branch || jump;
    tgt     = branch ? branch_addr : jump_addr;
    advance = (state == RUN) && (!if_valid || id_ready);
    pc_ok   = addr_ok(fetch_pc);
    tgt_ok  = addr_ok(tgt);
    rd_en   = advance && !redir && pc_ok;
  end

  imem_sp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (IMEM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .re    (rd_en),
    .raddr (fetch_pc[IW+1:2]),
    .we    (imem_we),
    .waddr (imem_waddr),
    .wdata (imem_wdata),
    .rdata (ir_out)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= BOOT;
      fetch_pc   <= RESET_PC;
      pc_out     <= RESET_PC;
      if_valid   <= 1'b0;
      fault      <= 1'b0;
      fault_addr <= '0;
    end else begin
      unique case (state)
        BOOT: state <= RUN;
        RUN: begin
          // Redirect wins over sequential fetch, even mid-stall.
          if (redir) begin
            if_valid <= 1'b0;
            if (tgt_ok) begin
              fetch_pc <= tgt;
            end else begin
              state      <= FAULT;
              fault      <= 1'b1;
              fault_addr <= tgt;
            end
          end else if (advance) begin
            if (pc_ok) begin
              pc_out   <= fetch_pc;
              if_valid <= 1'b1;
              fetch_pc <= fetch_pc + ADDR_W'(4);
            end else begin
              state      <= FAULT;
              fault      <= 1'b1;
              fault_addr <= fetch_pc;
              if_valid   <= 1'b0;
            end
          end
        end
        FAULT: state <= FAULT;
        default: state <= FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed-vector bench for instr_fetch_unit.
// Each task drives one scenario and checks outputs inline.
module tb_instr_fetch_unit;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 128;
  localparam int IW = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          branch, jump;
  logic [AW-1:0] branch_addr, jump_addr;
  logic          id_ready;
  logic          imem_we;
  logic [IW-1:0] imem_waddr;
  logic [DW-1:0] imem_wdata;
  logic [AW-1:0] pc_out;
  logic [DW-1:0] ir_out;
  logic          if_valid;
  logic          fault;
  logic [AW-1:0] fault_addr;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .IMEM_DEPTH (DEPTH),
    .RESET_PC   (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .branch      (branch),
    .jump        (jump),
    .branch_addr (branch_addr),
    .jump_addr   (jump_addr),
    .id_ready    (id_ready),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .pc_out      (pc_out),
    .ir_out      (ir_out),
    .if_valid    (if_valid),
    .fault       (fault),
    .fault_addr  (fault_addr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    branch = 0; jump = 0;
    branch_addr = '0; jump_addr = '0;
    id_ready = 1'b1;
    imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    // mem[i] = 0x11*(i+1) for i in 0..15, loaded under reset
    for (int i = 0; i < 16; i++) begin
      imem_we = 1'b1;
      imem_waddr = IW'(i);
      imem_wdata = 32'h11 * (i + 1);
      step();
    end
    imem_we = 1'b0;
    checks++;
    if (pc_out !== 32'h0 || ir_out !== 32'h0 || if_valid !== 1'b0 ||
        fault !== 1'b0 || fault_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset: pc=%h ir=%h v=%b f=%b fa=%h want 0/0/0/0/0",
               pc_out, ir_out, if_valid, fault, fault_addr);
    end
  endtask

  task automatic test_seq();
    logic [DW-1:0] exp_ir [4];
    exp_ir[0] = 32'h11; exp_ir[1] = 32'h22;
    exp_ir[2] = 32'h33; exp_ir[3] = 32'h44;
    rst = 1'b1;
    step();
    checks++;
    if (if_valid !== 1'b0) begin
      errors++;
      $display("FAIL boot_bubble: if_valid=%b want 0", if_valid);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (pc_out !== AW'(4 * i) || ir_out !== exp_ir[i] || if_valid !== 1'b1) begin
        errors++;
        $display("FAIL seq%0d: pc=%h ir=%h v=%b want %h/%h/1",
                 i, pc_out, ir_out, if_valid, 4 * i, exp_ir[i]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    step();
    step();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pc_out !== 32'h4 || ir_out !== 32'h22 || if_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall%0d: pc=%h ir=%h v=%b want 4/22/1",
                 i, pc_out, ir_out, if_valid);
      end
    end
    id_ready = 1'b1;
    step();
    checks++;
    if (pc_out !== 32'h8 || ir_out !== 32'h33 || if_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: pc=%h ir=%h v=%b want 8/33/1",
               pc_out, ir_out, if_valid);
    end
  endtask

  task automatic test_redirect_priority();
    branch = 1'b1; branch_addr = 32'h20;
    jump = 1'b1; jump_addr = 32'h40;
    step();
    branch = 1'b0; jump = 1'b0;
    checks++;
    if (if_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_bubble: if_valid=%b want 0", if_valid);
    end
    step();
    checks++;
    if (pc_out !== 32'h20 || ir_out !== 32'h99 || if_valid !== 1'b1) begin
      errors++;
      $display("FAIL redir_prio: pc=%h ir=%h v=%b want 20/99/1",
               pc_out, ir_out, if_valid);
    end
  endtask

  task automatic test_stall_redirect();
    id_ready = 1'b0;
    step();
    checks++;
    if (pc_out !== 32'h20 || if_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold: pc=%h v=%b want 20/1", pc_out, if_valid);
    end
    branch = 1'b1; branch_addr = 32'h10;
    step();
    branch = 1'b0;
    checks++;
    if (if_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_flush: if_valid=%b want 0", if_valid);
    end
    id_ready = 1'b1;
    step();
    checks++;
    if (pc_out !== 32'h10 || ir_out !== 32'h55 || if_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_redir: pc=%h ir=%h v=%b want 10/55/1",
               pc_out, ir_out, if_valid);
    end
  endtask

  task automatic test_reset_mid();
    step();
    step();
    checks++;
    if (pc_out !== 32'h18 || ir_out !== 32'h77) begin
      errors++;
      $display("FAIL pre_reset: pc=%h ir=%h want 18/77", pc_out, ir_out);
    end
    rst = 1'b0;
    step();
    checks++;
    if (pc_out !== 32'h0 || ir_out !== 32'h0 || if_valid !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: pc=%h ir=%h v=%b f=%b want 0/0/0/0",
               pc_out, ir_out, if_valid, fault);
    end
    rst = 1'b1;
    step();
    step();
    checks++;
    if (pc_out !== 32'h0 || ir_out !== 32'h11 || if_valid !== 1'b1) begin
      errors++;
      $display("FAIL resume: pc=%h ir=%h v=%b want 0/11/1",
               pc_out, ir_out, if_valid);
    end
  endtask

  task automatic test_fault_misaligned();
    jump = 1'b1; jump_addr = 32'h6;
    step();
    jump = 1'b0;
    checks++;
    if (fault !== 1'b1 || fault_addr !== 32'h6 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL misalign: f=%b fa=%h v=%b want 1/6/0",
               fault, fault_addr, if_valid);
    end
    branch = 1'b1; branch_addr = 32'h20;
    step();
    step();
    branch = 1'b0;
    checks++;
    if (fault !== 1'b1 || fault_addr !== 32'h6 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL fault_sticky: f=%b fa=%h v=%b want 1/6/0",
               fault, fault_addr, if_valid);
    end
  endtask

  task automatic test_fault_range();
    do_reset();
    branch = 1'b1; branch_addr = 32'h200;
    step();
    branch = 1'b0;
    checks++;
    if (fault !== 1'b1 || fault_addr !== 32'h200 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL range: f=%b fa=%h v=%b want 1/200/0",
               fault, fault_addr, if_valid);
    end
  endtask

  task automatic test_fallthrough();
    imem_we = 1'b1; imem_waddr = IW'(127); imem_wdata = 32'hDEAD;
    do_reset();
    imem_we = 1'b0;
    branch = 1'b1; branch_addr = 32'h1FC;
    step();
    branch = 1'b0;
    step();
    checks++;
    if (pc_out !== 32'h1FC || ir_out !== 32'hDEAD || if_valid !== 1'b1) begin
      errors++;
      $display("FAIL last_word: pc=%h ir=%h v=%b want 1fc/dead/1",
               pc_out, ir_out, if_valid);
    end
    step();
    checks++;
    if (fault !== 1'b1 || fault_addr !== 32'h200 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL fallthrough: f=%b fa=%h v=%b want 1/200/0",
               fault, fault_addr, if_valid);
    end
  endtask

  task automatic test_write_collision();
    do_reset();
    imem_we = 1'b1; imem_waddr = '0; imem_wdata = 32'hABCD;
    step();
    imem_we = 1'b0;
    checks++;
    if (pc_out !== 32'h0 || ir_out !== 32'h11 || if_valid !== 1'b1) begin
      errors++;
      $display("FAIL collide_old: pc=%h ir=%h v=%b want 0/11/1",
               pc_out, ir_out, if_valid);
    end
    jump = 1'b1; jump_addr = 32'h0;
    step();
    jump = 1'b0;
    step();
    checks++;
    if (pc_out !== 32'h0 || ir_out !== 32'hABCD || if_valid !== 1'b1) begin
      errors++;
      $display("FAIL collide_new: pc=%h ir=%h v=%b want 0/abcd/1",
               pc_out, ir_out, if_valid);
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_stall();
    test_redirect_priority();
    test_stall_redirect();
    test_reset_mid();
    test_fault_misaligned();
    test_fault_range();
    test_fallthrough();
    test_write_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Parametrised instruction-fetch stage for the MIPS core. It holds a word-addressed instruction memory with a load port and a fetch PC. It presents a coherent (pc_out, ir_out) pair to decode under a valid/ready handshake. Over the single-cycle fetch it adds stall, flush-on-redirect, branch-over-jump priority, and alignment/range fault detection.

Parameters:
ADDR_W, 32, width of PC and redirect targets
DATA_W, 32, instruction width
IMEM_DEPTH, 128, instruction words in memory (power of 2, >=2)
RESET_PC, 0, fetch address after reset (word aligned)

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous active-low reset
branch  in  1  taken-branch redirect request
jump  in  1  jump redirect request
branch_addr  in  ADDR_W  branch target
jump_addr  in  ADDR_W  jump target
id_ready  in  1  decode accepts current instruction
imem_we  in  1  instruction-memory load strobe
imem_waddr  in  clog2(IMEM_DEPTH)  word index to load
imem_wdata  in  DATA_W  word to load
pc_out  out  ADDR_W  byte address of ir_out
ir_out  out  DATA_W  fetched instruction
if_valid  out  1  pc_out/ir_out hold a valid instruction
fault  out  1  sticky fetch fault
fault_addr  out  ADDR_W  offending address

Behaviour:
- Reset (rst==0 at clk edge): fetch_pc=RESET_PC, pc_out=RESET_PC, ir_out=0, if_valid=0, fault=0, fault_addr=0, state=BOOT. Memory contents are not cleared.
- States:
  - BOOT: one cycle with no fetch, then RUN.
  - RUN: normal fetching.
  - FAULT: terminal; exited only by reset.
- advance = (state==RUN) && (!if_valid || id_ready).
- Fetch on advance, when fetch_pc is aligned and in range:
  - ir_out <= mem[fetch_pc[IDX_W+1:2]]
  - pc_out <= fetch_pc
  - if_valid <= 1
  - fetch_pc <= fetch_pc+4, wrapping mod 2^ADDR_W
- Latency: instruction at address A appears one cycle after fetch_pc==A is accepted. Pair is always coherent: pc_out is the address of ir_out.
- Stall: if_valid && !id_ready holds pc_out, ir_out, if_valid and fetch_pc unchanged.
- Redirect (branch||jump) sampled at clk in RUN:
  - Priority: branch over jump.
  - fetch_pc <= target; if_valid <= 0 (flushes the held instruction, even during a stall); no fetch that cycle.
  - Exactly one bubble before the target instruction is presented.
- Redirect in BOOT is ignored. Redirect in FAULT is ignored.
- Fault check applies to fetch_pc at advance time and to redirect targets at redirect time:
  - misaligned: addr[1:0]!=0
  - out of range: addr>>2 >= IMEM_DEPTH
  - Response: state <= FAULT, fault <= 1, fault_addr <= addr, if_valid <= 0, fetch_pc frozen, no memory read.
  - Sequential fall-through past the last word also faults.
- Memory load port:
  - Synchronous write when imem_we, in any state including BOOT and FAULT.
  - Write and fetch to the same index in the same cycle: the fetch returns the OLD word.
  - During reset the load port remains functional, so the bench can preload.
- Reset asserted mid-stall, mid-redirect or in FAULT overrides everything at that edge.

Decomposition:
- Shared package imem_pkg:
  - IDX_W = clog2(IMEM_DEPTH)
  - fetch state enum {BOOT, RUN, FAULT}
  - NOP_WORD = 32'h0000_0000
  - helper function word_index(addr)
- One natural sub-module, imem_sp_ram: synchronous read, synchronous write, read-old-data, parametrised DATA_W/IMEM_DEPTH.
- instr_fetch_unit holds the FSM, fetch_pc, output registers and fault logic.

Test Plan:
- Preload mem[0..3]=0x11,0x22,0x33,0x44; release reset; id_ready=1 -> cycle after BOOT shows pc_out 0/ir 0x11; then 4/0x22, 8/0x33, C/0x44 on consecutive cycles, if_valid=1 throughout.
- Fetching, id_ready=0 for 3 cycles while pc_out=4 -> pc_out 4/ir 0x22 held; on release next is 8/0x33, nothing skipped or duplicated.
- branch=1 to 0x20, jump=1 to 0x40 in the same cycle -> one if_valid=0 bubble, then pc_out=0x20 with ir=mem[8].
- Redirect to 0x10 while stalled with if_valid=1 -> stalled instruction dropped (if_valid=0), next valid pc_out=0x10.
- jump_addr=0x06 -> fault=1, fault_addr=0x06, if_valid stays 0; later branch ignored. Separately, target 0x200 with depth 128 -> fault_addr=0x200.
- Reset low for one edge mid-run at pc_out=0x18 -> next cycle pc_out=RESET_PC, ir_out=0, if_valid=0, fault=0; fetch resumes from 0 after BOOT.
